ws2812_frame_arbiter: RTL and testbench

//   Shares the ws2812 LED driver's pixel-write port between N_REQ frame sources.

---
 rtl/ws2812_frame_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ws2812_frame_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_arbiter.sv
// Round-robin arbiter that lets one of N_REQ frame sources at a time stream NUM_LEDS
// pixels, scaled by a per-frame brightness, into the ws2812 driver's write port.
module ws2812_frame_arbiter #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      px_valid,
  input  logic [24*N_REQ-1:0]   px_data,
  output logic [N_REQ-1:0]      px_ready,
  output logic [N_REQ-1:0]      grant,
  input  logic [7:0]            brightness,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic [23:0]           rgb_data,
  output logic [7:0]            led_num,
  output logic                  write
);

  localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  LAST_IDX = 8'(NUM_LEDS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     rr_q, rr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [7:0]        bright_q, bright_d;
  logic [7:0]        idx_q, idx_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [7:0]        led_q, led_d;

  logic              pick_found;
  logic [OW-1:0]     pick_idx;
  logic              sel_req;
  logic [23:0]       sel_pix;
  logic              accept;
  logic [OW-1:0]     rr_next;
  logic [8:0]        bright_p1;

  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [8:0] b1);
    logic [15:0] p;
    p = 16'(c) * 16'(b1);
    return p[15:8];
  endfunction

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    int unsigned j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!pick_found && req[OW'(j)]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(j);
      end
    end
  end

  // Owner's request and pixel.
  always_comb begin
    sel_req = 1'b0;
    sel_pix = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        sel_req = req[i];
        sel_pix = px_data[24*i +: 24];
      end
    end
  end

  assign accept    = |(px_valid & ready_q);
  assign rr_next   = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
  assign bright_p1 = 9'(bright_q) + 9'd1;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    bright_d = bright_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    grant_d  = grant_q;
    ready_d  = ready_q;
    write_d  = 1'b0;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    rgb_d    = rgb_q;
    led_d    = led_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d  = pick_idx;
          grant_d  = N_REQ'(1) << pick_idx;
          ready_d  = N_REQ'(1) << pick_idx;
          bright_d = brightness;
          idx_d    = '0;
          tmo_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          write_d = 1'b1;
          led_d   = idx_q;
          rgb_d   = {scale8(sel_pix[23:16], bright_p1),
                     scale8(sel_pix[15:8],  bright_p1),
                     scale8(sel_pix[7:0],   bright_p1)};
          idx_d   = idx_q + 8'd1;
          tmo_d   = '0;
        end
        // The last-pixel accept outranks any abort raised in the same cycle.
        if (accept && idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          grant_d = '0;
          ready_d = '0;
          rr_d    = rr_next;
          state_d = S_IDLE;
        end else if (!sel_req || (!accept && tmo_q == TMO_LAST)) begin
          abort_d = 1'b1;
          grant_d = '0;
          ready_d = '0;
          rr_d    = rr_next;
          state_d = S_IDLE;
        end else if (!accept) begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      bright_q <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      grant_q  <= '0;
      ready_q  <= '0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      rgb_q    <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      bright_q <= bright_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      write_q  <= write_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      rgb_q    <= rgb_d;
      led_q    <= led_d;
    end
  end

  assign grant       = grant_q;
  assign px_ready    = ready_q;
  assign write       = write_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign rgb_data    = rgb_q;
  assign led_num     = led_q;

endmodule

// File: tb/tb_ws2812_frame_arbiter.sv
// Bench for ws2812_frame_arbiter: pixel sources push expected writes to a scoreboard,
// a monitor pops them on each write; scenario tasks check grant, abort and timing.
module tb_ws2812_frame_arbiter;

  localparam int unsigned NL = 8;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     px_valid;
  logic [24*NR-1:0]  px_data;
  logic [NR-1:0]     px_ready;
  logic [NR-1:0]     grant;
  logic [7:0]        brightness;
  logic              frame_done;
  logic              frame_abort;
  logic [23:0]       rgb_data;
  logic [7:0]        led_num;
  logic              write;

  ws2812_frame_arbiter #(.NUM_LEDS(NL), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .px_valid(px_valid), .px_data(px_data),
    .px_ready(px_ready), .grant(grant), .brightness(brightness),
    .frame_done(frame_done), .frame_abort(frame_abort), .rgb_data(rgb_data),
    .led_num(led_num), .write(write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  led;
    logic [23:0] rgb;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_pass = 0;
  int          n_total = 0;
  int          lim[NR];
  int          cnt[NR];
  logic [7:0]  lat_b;
  bit          fixed_mode;
  logic [23:0] fixed_pix;
  logic [NR-1:0] src_acc;
  logic [23:0]   src_p;

  function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] b);
    int p;
    p = int'(c) * (int'(b) + 1);
    return 8'(p >> 8);
  endfunction

  function automatic logic [23:0] scale24(input logic [23:0] p, input logic [7:0] b);
    return {sc(p[23:16], b), sc(p[15:8], b), sc(p[7:0], b)};
  endfunction

  function automatic logic [23:0] newpix();
    return fixed_mode ? fixed_pix : 24'($urandom);
  endfunction

  // Pixel sources: predict each accept and queue the write it must produce.
  always begin
    @(negedge clk);
    src_acc = px_valid & px_ready;
    if (grant == '0) lat_b = brightness;
    for (int i = 0; i < NR; i++) begin
      if (!grant[i]) begin
        cnt[i] = 0;
        px_valid[i] = (lim[i] != 0);
        px_data[i*24 +: 24] = newpix();
      end else if (src_acc[i]) begin
        src_p = px_data[i*24 +: 24];
        sb.push_back({8'(cnt[i]), scale24(src_p, lat_b), cnt[i] == NL - 1});
      end
    end
    if (src_acc != '0) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (src_acc[i]) begin
          cnt[i]++;
          if (cnt[i] >= lim[i]) px_valid[i] = 1'b0;
          px_data[i*24 +: 24] = newpix();
        end
      end
    end
  end

  // Monitor: every write must match the oldest predicted pixel.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got led_num=%0d rgb=%h, required no write", led_num, rgb_data);
      end else begin
        mon_e = sb.pop_front();
        if ({led_num, rgb_data, frame_done} !== {mon_e.led, mon_e.rgb, mon_e.last})
          $display("FAIL write_beat: got led=%0d rgb=%h done=%b, required led=%0d rgb=%h done=%b",
                   led_num, rgb_data, frame_done, mon_e.led, mon_e.rgb, mon_e.last);
        else n_pass++;
      end
    end
    if (frame_done === 1'b1) begin
      n_total++;
      if (write !== 1'b1) $display("FAIL done_with_write: got write=%b, required 1", write);
      else n_pass++;
    end
    if (grant !== '0) begin
      n_total++;
      if (px_ready !== grant || !$onehot(grant))
        $display("FAIL ready_grant: got grant=%b px_ready=%b, required one-hot and equal", grant, px_ready);
      else n_pass++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (grant !== '0 || px_ready !== '0) $display("FAIL rst_grant: got %b/%b, required 0/0", grant, px_ready);
    else n_pass++;
    n_total++;
    if (write !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0)
      $display("FAIL rst_pulses: got %b%b%b, required 000", write, frame_done, frame_abort);
    else n_pass++;
    n_total++;
    if (rgb_data !== 24'h0 || led_num !== 8'h0)
      $display("FAIL rst_data: got %h/%h, required 0/0", rgb_data, led_num);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    int nw = 0, nab = 0;
    bit got = 0;
    apply_reset();
    brightness = 8'd255;
    lim = '{8, 8};
    @(negedge clk);
    req = 2'b01;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (write) nw++;
      if (frame_abort) nab++;
      if (frame_done) begin got = 1; req = '0; end
    end
    n_total++;
    if (!got || nw != 8 || nab != 0)
      $display("FAIL single_frame: got done=%0d writes=%0d aborts=%0d, required 1/8/0", got, nw, nab);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (grant !== '0 || sb.size() != 0)
      $display("FAIL single_idle: got grant=%b pending=%0d, required 0/0", grant, sb.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] gseq[4];
    logic [NR-1:0] prev = '0;
    int ng = 0, idle_run = 0, nw = 0, bad_gap = 0;
    bit fin = 0;
    apply_reset();
    brightness = 8'd200;
    lim = '{8, 8};
    @(negedge clk);
    req = 2'b11;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (write) nw++;
      if (grant != '0 && prev == '0 && ng < 4) begin
        gseq[ng] = grant;
        if (ng > 0 && idle_run != 1) bad_gap++;
        ng++;
      end
      idle_run = (grant == '0) ? idle_run + 1 : 0;
      prev = grant;
      if (frame_done && ng == 4) begin fin = 1; req = '0; end
    end
    n_total++;
    if (!fin || ng != 4) $display("FAIL rr_frames: got %0d grants, required 4", ng);
    else n_pass++;
    for (int k = 0; k < 4 && k < ng; k++) begin
      n_total++;
      if (gseq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL rr_order%0d: got %b, required %b", k, gseq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    n_total++;
    if (bad_gap != 0 || nw != 32) $display("FAIL rr_gap: got bad_gaps=%0d writes=%0d, required 0/32", bad_gap, nw);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scaling();
    logic [23:0] first;
    int nw;
    bit got;
    logic [7:0] bset[2] = '{8'd127, 8'd0};
    logic [23:0] want[2] = '{24'h7F4000, 24'h000000};
    apply_reset();
    fixed_mode = 1'b1;
    fixed_pix = 24'hFF8001;
    lim = '{8, 8};
    for (int f = 0; f < 2; f++) begin
      brightness = bset[f];
      @(negedge clk);
      req = 2'b01;
      nw = 0; got = 0; first = 24'hxxxxxx;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (write) begin
          if (nw == 0) first = rgb_data;
          nw++;
          if (nw == 2) begin #1 brightness = ~bset[f]; end
        end
        if (frame_done) begin got = 1; req = '0; end
      end
      n_total++;
      if (first !== want[f]) $display("FAIL scale_b%0d: got %h, required %h", bset[f], first, want[f]);
      else n_pass++;
      @(negedge clk);
    end
    fixed_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int nw = 0, nd = 0, last_w = 0, ab_c = -100;
    bit ab = 0, got = 0;
    apply_reset();
    brightness = 8'd255;
    lim = '{3, 8};
    @(negedge clk);
    req = 2'b11;
    for (int c = 0; c < 100 && !ab; c++) begin
      @(negedge clk);
      if (write) begin nw++; last_w = c; end
      if (frame_done) nd++;
      if (frame_abort) begin ab = 1; ab_c = c; end
    end
    n_total++;
    if (!ab || ab_c - last_w != 4)
      $display("FAIL tmo_delay: got abort=%0d after %0d cycles, required 1 after 4", ab, ab_c - last_w);
    else n_pass++;
    n_total++;
    if (nw != 3 || nd != 0) $display("FAIL tmo_writes: got writes=%0d done=%0d, required 3/0", nw, nd);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant !== 2'b10) $display("FAIL tmo_next_grant: got %b, required 10", grant);
    else n_pass++;
    req = 2'b10;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; req = '0; end
    end
    n_total++;
    if (!got) $display("FAIL tmo_second_frame: got no frame_done, required one");
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_req_drop();
    int nw = 0, nd = 0, drop_c = -100, ab_c = -100;
    bit dropped = 0, ab = 0, got = 0;
    apply_reset();
    brightness = 8'd90;
    lim = '{6, 8};
    @(negedge clk);
    req = 2'b11;
    for (int c = 0; c < 100 && !ab; c++) begin
      @(negedge clk);
      if (frame_abort) begin ab = 1; ab_c = c; end
      if (frame_done) nd++;
      if (write) nw++;
      if (nw == 6 && !dropped) begin req[0] = 1'b0; dropped = 1; drop_c = c; end
    end
    n_total++;
    if (!ab || ab_c != drop_c + 1) $display("FAIL drop_abort: got abort=%0d at +%0d, required 1 at +1", ab, ab_c - drop_c);
    else n_pass++;
    n_total++;
    if (nw != 6 || nd != 0) $display("FAIL drop_writes: got writes=%0d done=%0d, required 6/0", nw, nd);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (grant !== 2'b10) $display("FAIL drop_rr: got %b, required 10", grant);
    else n_pass++;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (frame_done) begin got = 1; req = '0; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_load();
    bit hit = 0, got = 0;
    apply_reset();
    brightness = 8'd255;
    lim = '{8, 8};
    @(negedge clk);
    req = 2'b01;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (write && led_num == 8'd3) hit = 1;
    end
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (!hit || write !== 1'b0 || grant !== '0 || px_ready !== '0)
      $display("FAIL mid_reset: got hit=%0d write=%b grant=%b ready=%b, required 1/0/00/00", hit, write, grant, px_ready);
    else n_pass++;
    @(negedge clk);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    req = 2'b11;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (write) begin
        got = 1;
        n_total++;
        if (grant !== 2'b01 || led_num !== 8'd0)
          $display("FAIL post_reset_start: got grant=%b led=%0d, required 01/0", grant, led_num);
        else n_pass++;
      end
    end
    if (!got) begin n_total++; $display("FAIL post_reset_start: got no write, required one"); end
    req = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    px_valid = '0;
    px_data = '0;
    brightness = 8'd255;
    lat_b = 8'd255;
    fixed_mode = 1'b0;
    fixed_pix = '0;
    lim = '{0, 0};
    cnt = '{0, 0};
    test_reset();
    test_single_frame();
    test_round_robin();
    test_scaling();
    test_timeout();
    test_req_drop();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

endmodule
